// File: rtl/cmac_atom_seq.sv
// Sequences one INT8 8-lane MAC through an N-atom dot product: issues N atoms,
// collects and sums N partial results, then presents the total with valid/ready.
module cmac_atom_seq #(
   parameter int ATOM_CNT_W = 8,
   parameter int MAC_OUT_W  = 19,
   parameter int ACC_W      = 27
) (
   input  logic                        nvdla_core_clk,
   input  logic                        nvdla_core_rstn,
   input  logic                        op_start,
   input  logic [ATOM_CNT_W-1:0]       op_atoms,
   output logic                        op_busy,
   input  logic                        in_pvld,
   output logic                        in_prdy,
   input  logic [7:0]                  in_mask,
   output logic [7:0]                  mac_pvld,
   output logic [7:0]                  mac_lane_en,
   input  logic signed [MAC_OUT_W-1:0] mac_out_data,
   input  logic                        mac_out_pvld,
   output logic                        res_pvld,
   input  logic                        res_prdy,
   output logic signed [ACC_W-1:0]     res_data,
   output logic [ATOM_CNT_W-1:0]       res_atoms,
   output logic                        err_unexp
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [ATOM_CNT_W-1:0]     r_n;
   logic [ATOM_CNT_W-1:0]     r_issue_cnt;
   logic [ATOM_CNT_W-1:0]     r_recv_cnt;
   logic signed [ACC_W-1:0]   r_acc;
   logic                      r_err;

   logic                      w_start;
   logic                      w_fire;
   logic                      w_collect;
   logic                      w_take;
   logic                      w_unexp;
   logic                      w_last_iss;
   logic                      w_last_res;
   logic [ATOM_CNT_W-1:0]     w_n_m1;

   function automatic logic signed [ACC_W-1:0] sext_mac(input logic signed [MAC_OUT_W-1:0] v);
      return {{(ACC_W-MAC_OUT_W){v[MAC_OUT_W-1]}}, v};
   endfunction

   assign w_n_m1     = r_n - ATOM_CNT_W'(1);
   assign w_start    = (r_state == S_IDLE) && op_start && (op_atoms != '0);
   assign w_fire     = in_pvld && (r_state == S_RUN);
   // Results are only legal while an operation still owes some; anything else is flagged and dropped.
   assign w_collect  = ((r_state == S_RUN) || (r_state == S_DRAIN)) && (r_recv_cnt != r_n);
   assign w_take     = mac_out_pvld && w_collect;
   assign w_unexp    = mac_out_pvld && !w_collect;
   assign w_last_iss = w_fire && (r_issue_cnt == w_n_m1);
   assign w_last_res = w_take && (r_recv_cnt == w_n_m1);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_RUN;
         // Final result arriving in RUN (zero-latency MAC) takes priority over DRAIN.
         S_RUN: begin
            if (w_last_res)      w_state_nxt = S_OUT;
            else if (w_last_iss) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (w_last_res) w_state_nxt = S_OUT;
         S_OUT:   if (res_prdy)   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
         r_acc       <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= (r_err && !w_start) || w_unexp;
         if (w_start) begin
            r_n         <= op_atoms;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_acc       <= '0;
         end else begin
            if (w_fire) r_issue_cnt <= r_issue_cnt + ATOM_CNT_W'(1);
            if (w_take) begin
               r_recv_cnt <= r_recv_cnt + ATOM_CNT_W'(1);
               r_acc      <= r_acc + sext_mac(mac_out_data);
            end
         end
      end
   end

   assign op_busy     = (r_state != S_IDLE);
   assign in_prdy     = (r_state == S_RUN);
   assign mac_pvld    = {8{w_fire}};
   assign mac_lane_en = in_mask & {8{w_fire}};
   assign res_pvld    = (r_state == S_OUT);
   assign res_data    = r_acc;
   assign res_atoms   = r_n;
   assign err_unexp   = r_err;

endmodule

// File: tb/tb_cmac_atom_seq.sv
// Bench for cmac_atom_seq: a 3-cycle MAC model feeds queued partial sums back,
// and a sum-of-queue reference gives the expected result for each operation.
module tb_cmac_atom_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_start;
   logic [7:0]  op_atoms;
   logic        op_busy;
   logic        in_pvld;
   logic        in_prdy;
   logic [7:0]  in_mask;
   logic [7:0]  mac_pvld;
   logic [7:0]  mac_lane_en;
   logic [18:0] mac_out_data;
   logic        mac_out_pvld;
   logic        res_pvld;
   logic        res_prdy;
   logic [26:0] res_data;
   logic [7:0]  res_atoms;
   logic        err_unexp;

   int          checks = 0;
   int          errors = 0;
   logic [26:0] g_res;

   // MAC pipeline model: three register stages from fire to result
   int          mac_vals[$];
   logic [2:0]  p_v = '0;
   logic [18:0] p_d0 = '0, p_d1 = '0, p_d2 = '0;
   logic        inj_v = 1'b0;
   logic [18:0] inj_d = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      p_v  <= {p_v[1:0], |mac_pvld};
      p_d1 <= p_d0;
      p_d2 <= p_d1;
      if ((|mac_pvld) && (mac_vals.size() > 0)) p_d0 <= 19'(mac_vals.pop_front());
      else p_d0 <= '0;
   end

   assign mac_out_pvld = p_v[2] | inj_v;
   assign mac_out_data = inj_v ? inj_d : p_d2;

   cmac_atom_seq dut (
      .nvdla_core_clk  (clk),
      .nvdla_core_rstn (rst_n),
      .op_start        (op_start),
      .op_atoms        (op_atoms),
      .op_busy         (op_busy),
      .in_pvld         (in_pvld),
      .in_prdy         (in_prdy),
      .in_mask         (in_mask),
      .mac_pvld        (mac_pvld),
      .mac_lane_en     (mac_lane_en),
      .mac_out_data    (mac_out_data),
      .mac_out_pvld    (mac_out_pvld),
      .res_pvld        (res_pvld),
      .res_prdy        (res_prdy),
      .res_data        (res_data),
      .res_atoms       (res_atoms),
      .err_unexp       (err_unexp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd_val();
      return int'($urandom_range(524287, 0)) - 262144;
   endfunction

   // mode: 0 = in_pvld always 1, 1 = alternating 1,0,1..., 2 = random
   task automatic run_op(input int n, input int mode, input int hold, input bit inj);
      longint      s = 0;
      logic [26:0] exp_d;
      int          fires = 0, prdy_cyc = 0, last_fire = -100, cyc;
      bit          got = 0;
      bit          exp_prdy, exp_fire;
      foreach (mac_vals[i]) s += longint'(mac_vals[i]);
      exp_d = s[26:0];

      @(posedge clk); #1;
      op_start = 1'b1; op_atoms = n[7:0]; in_pvld = 1'b0; res_prdy = 1'b0;
      @(posedge clk); #1;
      op_start = 1'b0;
      chk("start_busy", op_busy, 1);
      chk("start_err_clr", err_unexp, 0);

      for (cyc = 0; cyc < 3000; cyc++) begin
         if (res_pvld === 1'b1) begin
            got = 1;
            break;
         end
         case (mode)
            0:       in_pvld = 1'b1;
            1:       in_pvld = (cyc % 2 == 0);
            default: in_pvld = $urandom_range(1, 0) == 1;
         endcase
         in_mask = 8'($urandom);
         #1;
         exp_prdy = (fires < n);
         exp_fire = in_pvld && exp_prdy;
         chk("in_prdy", in_prdy, exp_prdy);
         chk("mac_pvld", mac_pvld, {8{exp_fire}});
         chk("mac_lane_en", mac_lane_en, in_mask & {8{exp_fire}});
         if (in_prdy) prdy_cyc++;
         if (exp_fire) begin
            fires++;
            last_fire = cyc;
         end
         @(posedge clk); #1;
      end
      in_pvld = 1'b0;
      chk("res_seen", got, 1);
      if (got) begin
         chk("fires_total", fires, n);
         chk("res_latency", cyc - last_fire, 4);
         chk("res_data", res_data, exp_d);
         chk("res_atoms", res_atoms, n[7:0]);
         if (mode == 0) chk("prdy_cycles", prdy_cyc, n);
         g_res = res_data;
         for (int h = 0; h < hold; h++) begin
            op_start = 1'b1;
            op_atoms = 8'($urandom_range(255, 1));
            inj_v = inj && (h == 0);
            inj_d = 19'h12345;
            @(posedge clk); #1;
            inj_v = 1'b0;
            chk("hold_pvld", res_pvld, 1);
            chk("hold_data", res_data, exp_d);
            chk("hold_atoms", res_atoms, n[7:0]);
         end
         if (inj) chk("inj_err", err_unexp, 1);
         op_start = 1'b0;
         res_prdy = 1'b1;
         @(posedge clk); #1;
         res_prdy = 1'b0;
         chk("ret_pvld", res_pvld, 0);
         chk("ret_busy", op_busy, 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; op_start = 1'b0; op_atoms = '0;
      in_pvld = 1'b1; in_mask = 8'hFF; res_prdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", op_busy, 0);
      chk("rst_prdy", in_prdy, 0);
      chk("rst_res_pvld", res_pvld, 0);
      chk("rst_err", err_unexp, 0);
      chk("rst_data", res_data, 0);
      chk("rst_atoms", res_atoms, 0);
      chk("rst_mac_pvld", mac_pvld, 0);
      chk("rst_lane_en", mac_lane_en, 0);
      in_pvld = 1'b0;
      rst_n = 1'b1;

      // start with zero atoms is ignored
      @(posedge clk); #1;
      op_start = 1'b1; op_atoms = 8'd0;
      @(posedge clk); #1;
      op_start = 1'b0;
      chk("zero_n_busy", op_busy, 0);
      chk("zero_n_prdy", in_prdy, 0);

      mac_vals = '{100, -50, 7, 1};
      run_op(4, 0, 0, 0);
      chk("n4_const", g_res, 27'd58);

      mac_vals = '{-262144};
      run_op(1, 0, 0, 0);
      chk("n1_min_const", g_res, 27'h7FC0000);

      mac_vals.delete();
      for (int i = 0; i < 255; i++) mac_vals.push_back(262143);
      run_op(255, 0, 0, 0);
      chk("n255_const", g_res, 27'd66846465);

      mac_vals.delete();
      for (int i = 0; i < 3; i++) mac_vals.push_back(rnd_val());
      run_op(3, 1, 0, 0);

      mac_vals = '{rnd_val(), rnd_val()};
      run_op(2, 0, 5, 1);

      // reset while draining with two results still inside the MAC pipeline
      mac_vals = '{11, 22, 33, 44};
      @(posedge clk); #1;
      op_start = 1'b1; op_atoms = 8'd4;
      @(posedge clk); #1;
      op_start = 1'b0; in_pvld = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      in_pvld = 1'b0;
      chk("drain_busy", op_busy, 1);
      chk("drain_prdy", in_prdy, 0);
      @(posedge clk); #1;
      rst_n = 1'b0; in_pvld = 1'b1; in_mask = 8'hA5;
      #1;
      chk("mid_rst_busy", op_busy, 0);
      chk("mid_rst_res_pvld", res_pvld, 0);
      chk("mid_rst_data", res_data, 0);
      chk("mid_rst_atoms", res_atoms, 0);
      chk("mid_rst_mac_pvld", mac_pvld, 0);
      chk("mid_rst_err", err_unexp, 0);
      #1;
      rst_n = 1'b1; in_pvld = 1'b0;
      @(posedge clk); #1;
      chk("late_res_err1", err_unexp, 1);
      chk("late_res_busy", op_busy, 0);
      @(posedge clk); #1;
      chk("late_res_err2", err_unexp, 1);
      chk("late_res_data", res_data, 0);

      mac_vals = '{-5};
      run_op(1, 0, 0, 0);

      for (int k = 0; k < 8; k++) begin
         int n;
         n = int'($urandom_range(24, 1));
         mac_vals.delete();
         for (int i = 0; i < n; i++) mac_vals.push_back(rnd_val());
         run_op(n, 2, int'($urandom_range(3, 0)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmac_atom_seq.md
Name: cmac_atom_seq

Overview:
- Sequences one INT8 8-lane MAC unit through a multi-atom dot-product operation.
- Accepts an operation length N in atoms and streams N atoms from upstream into the MAC with a valid/ready handshake. Drives the MAC lane-valid and lane-enable vectors.
- Counts MAC results as they return and accumulates them into a wide signed sum, then presents one result with a valid/ready handshake.
- Sits between the CMAC data/weight feeder and the accumulation stage.

Parameters:
ATOM_CNT_W, 8, width of atom count; maximum N = 2^ATOM_CNT_W-1
MAC_OUT_W, 19, width of MAC partial sum (signed)
ACC_W, 27, accumulator width = MAC_OUT_W+ATOM_CNT_W; must be >= that sum (no overflow possible)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rstn  in  1  asynchronous active-low reset
op_start  in  1  start pulse; sampled only in IDLE
op_atoms  in  ATOM_CNT_W  atom count N for the operation; N=0 ignored
op_busy  out  1  high in any state except IDLE
in_pvld  in  1  upstream atom valid
in_prdy  out  1  upstream atom ready
in_mask  in  8  per-lane enable for the current atom
mac_pvld  out  8  to MAC dat/wt pvld; all bits = fire
mac_lane_en  out  8  in_mask & {8{fire}}; ANDed externally with the nz vectors
mac_out_data  in  MAC_OUT_W  signed MAC partial sum
mac_out_pvld  in  1  MAC result valid
res_pvld  out  1  result valid
res_prdy  in  1  result ready
res_data  out  ACC_W  signed accumulated result
res_atoms  out  ATOM_CNT_W  N of the completed operation
err_unexp  out  1  sticky: mac_out_pvld seen while not expecting a result

Behaviour:
- Reset (async, rstn=0) values:
  - state=IDLE; op_busy, in_prdy, res_pvld, err_unexp = 0.
  - res_data, res_atoms, all counters and the accumulator = 0.
  - mac_pvld and mac_lane_en are combinational from fire, so they are 0 in reset.
- fire = in_pvld & in_prdy. in_prdy is 1 only in RUN.
- IDLE:
  - op_start=1 and op_atoms!=0: latch N, clear issue_cnt, recv_cnt and acc; go to RUN next cycle. err_unexp clears on this accepted start.
  - op_start=1 with op_atoms=0: no effect, stay IDLE.
- RUN:
  - Each fire increments issue_cnt.
  - When fire occurs with issue_cnt==N-1, go to DRAIN next cycle; in_prdy=0 from that cycle.
  - At most N atoms are ever issued.
- DRAIN: in_prdy=0. Waits for the remaining results.
- Result collection (RUN and DRAIN):
  - Each mac_out_pvld does acc <= acc + sign_extend(mac_out_data) and recv_cnt++.
  - When the result with recv_cnt==N-1 is accepted, go to OUT next cycle. The final result is included in acc.
  - This transition is legal directly from RUN: it is possible in the same cycle as the last fire only if MAC latency were 0, but the implementation must handle it anyway.
- OUT:
  - res_pvld=1; res_data=acc; res_atoms=N. Both are held stable while res_prdy=0.
  - When res_prdy=1: go to IDLE next cycle; res_pvld drops.
- Unexpected results:
  - mac_out_pvld in IDLE or OUT, or in RUN/DRAIN with recv_cnt already == N, sets err_unexp.
  - The data is not accumulated and counters do not change.
- op_start outside IDLE is ignored.
- Latency: with the 3-cycle MAC pipeline, last fire at cycle t gives mac_out_pvld at t+3 and res_pvld at t+4. Minimum op_start to first in_prdy is 1 cycle.
- Arithmetic:
  - Two's complement throughout.
  - Worst case N*(±2^18) fits in ACC_W, so no saturation or wrap is required.
- Reset mid-operation: immediately returns to IDLE with all outputs at reset values. In-flight MAC results arriving after reset set err_unexp (state is IDLE).
- Back-pressure: in_pvld may drop mid-operation. issue_cnt holds, and mac_pvld is 0 in that cycle.

Test Plan:
- Start N=4; in_pvld always 1; MAC outputs 100, -50, 7, 1 -> in_prdy high for exactly 4 cycles; res_pvld 4 cycles after the last fire; res_data=58; res_atoms=4.
- N=1; MAC result -262144 (min 19-bit) -> res_data = -262144 sign-extended to 27 bits (0x7FC0000).
- N=255; every result +262143 -> res_data = 66846465, with no overflow.
- N=3; in_pvld toggles 1,0,1,0,1 -> mac_pvld=0xFF only on the 3 fire cycles; mac_lane_en = in_mask on those cycles; total issued = 3.
- Result held with res_prdy=0 for 5 cycles -> res_data stable and res_pvld=1 throughout; a second op_start during this window is ignored; returns to IDLE the cycle after res_prdy=1.
- Reset asserted during DRAIN with 2 results pending, then MAC emits 2 pvld after release -> all outputs 0 after reset; err_unexp=1; next valid op_start clears err_unexp.
